// File: rtl/rf_mp_sb.sv
// rf_mp_sb: multi-port integer register file with a per-register busy scoreboard.
// NR combinational read ports and two writeback lanes (lane 1 is younger and wins).
// With BYPASS=1, same-cycle writeback data and busy clears are forwarded to the read ports.
// Register 0 is hardwired to zero and is never marked busy.
module rf_mp_sb #(
   parameter int DW     = 32,
   parameter int NREG   = 32,
   parameter int AW     = 5,
   parameter int NR     = 2,
   parameter int BYPASS = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NR*AW-1:0]     raddr,
   output logic [NR*DW-1:0]     rdata,
   output logic [NR-1:0]        rbusy,
   input  logic                 we0,
   input  logic [AW-1:0]        waddr0,
   input  logic [DW-1:0]        wdata0,
   input  logic                 we1,
   input  logic [AW-1:0]        waddr1,
   input  logic [DW-1:0]        wdata1,
   input  logic                 iss_valid,
   input  logic [AW-1:0]        iss_addr,
   output logic                 any_busy
);

   // Effective lane enables: ignore address 0 and anything seen while in reset,
   // so that bypass is inhibited during reset as well.
   logic w_we0;
   logic w_we1;
   logic w_iss;

   assign w_we0 = rst_n && we0 && (waddr0 != '0);
   assign w_we1 = rst_n && we1 && (waddr1 != '0);
   assign w_iss = iss_valid && (iss_addr != '0);

   // Flattened view of stored state; entry 0 is the constant-zero register.
   logic [NREG-1:0][DW-1:0] w_mem;
   logic [NREG-1:0]         w_busy;

   assign w_mem[0]  = '0;
   assign w_busy[0] = 1'b0;

   genvar gi;
   generate
      for (gi = 1; gi < NREG; gi++) begin : g_reg
         logic [DW-1:0] r_val;
         logic          r_busy;
         logic          w_hit0;
         logic          w_hit1;
         logic          w_set;

         assign w_hit0 = w_we0 && (waddr0 == AW'(gi));
         assign w_hit1 = w_we1 && (waddr1 == AW'(gi));
         assign w_set  = w_iss && (iss_addr == AW'(gi));

         // Storage: lane 1 has priority when both lanes target this register.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_val <= '0;
            end else if (w_hit1) begin
               r_val <= wdata1;
            end else if (w_hit0) begin
               r_val <= wdata0;
            end
         end

         // Busy bit: an issue on the same edge as a writeback keeps it set,
         // because a new producer has just been issued as the old one retires.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_busy <= 1'b0;
            end else if (w_set) begin
               r_busy <= 1'b1;
            end else if (w_hit0 || w_hit1) begin
               r_busy <= 1'b0;
            end
         end

         assign w_mem[gi]  = r_val;
         assign w_busy[gi] = r_busy;
      end

      for (gi = 0; gi < NR; gi++) begin : g_rd
         logic [AW-1:0] w_ra;
         logic          w_byp0;
         logic          w_byp1;

         assign w_ra = raddr[gi*AW +: AW];

         if (BYPASS != 0) begin : g_byp
            assign w_byp0 = w_we0 && (waddr0 == w_ra);
            assign w_byp1 = w_we1 && (waddr1 == w_ra);
         end else begin : g_nobyp
            assign w_byp0 = 1'b0;
            assign w_byp1 = 1'b0;
         end

         // Read mux: forwarded lane 1, then lane 0, then stored value.
         assign rdata[gi*DW +: DW] = w_byp1 ? wdata1 :
                                     w_byp0 ? wdata0 : w_mem[w_ra];

         // Data arriving this cycle counts as ready when forwarding is enabled.
         assign rbusy[gi] = w_busy[w_ra] && !(w_byp0 || w_byp1);
      end
   endgenerate

   assign any_busy = |w_busy;

endmodule

// File: doc/rf_mp_sb.md
Name: rf_mp_sb

Overview:
- Parametrised multi-port integer register file for the pipelined core.
- Provides NR combinational read ports and two write ports (WB0, WB1 lanes).
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard set at issue and cleared at writeback, so the decode stage can detect RAW hazards without a separate hazard table.

Parameters:
- DW, 32, data width in bits.
- NREG, 32, number of architectural registers. Must be a power of two and ≥ 2.
- AW, 5, address width. Must equal log2(NREG).
- NR, 2, number of read ports (≥ 1).
- BYPASS, 1, 1 = a same-cycle write is visible on the read ports; 0 = reads show stored state only.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- raddr  in  NR*AW  read addresses; port k is bits [k*AW +: AW].
- rdata  out  NR*DW  read data; port k is bits [k*DW +: DW].
- rbusy  out  NR  scoreboard busy flag for each read address.
- we0  in  1  write enable, lane 0.
- waddr0  in  AW  write address, lane 0.
- wdata0  in  DW  write data, lane 0.
- we1  in  1  write enable, lane 1.
- waddr1  in  AW  write address, lane 1.
- wdata1  in  DW  write data, lane 1.
- iss_valid  in  1  an instruction with a destination register issues this cycle.
- iss_addr  in  AW  destination register of the issuing instruction.
- any_busy  out  1  OR of all busy bits (pipeline drain indicator).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset state:
  - While rst_n = 0, all NREG-1 storage entries and all busy bits are forced to 0.
  - Writes and issues are ignored during reset.
  - Outputs during reset: rdata = 0 on all ports, rbusy = 0, any_busy = 0. Bypass is inhibited while rst_n = 0.
  - Deassertion takes effect asynchronously; the first write is accepted on the first rising edge with rst_n = 1.
- Register 0:
  - Hardwired to 0. Writes to address 0 are dropped on both lanes.
  - busy[0] is never set; iss_addr = 0 is ignored.
  - Reading address 0 returns 0 and rbusy = 0, including under bypass.
- Write (one-cycle latency):
  - On a rising edge, lane L stores wdataL at waddrL when weL = 1 and waddrL ≠ 0.
  - If both lanes target the same nonzero address in one cycle, lane 1 wins (it is the younger writeback) and lane 0's data is discarded.
- Read (combinational, zero latency):
  - BYPASS = 0: rdata[k] is the stored value of raddr[k].
  - BYPASS = 1: if a lane writes raddr[k] this cycle, rdata[k] is that lane's wdata, with lane 1 taking priority over lane 0. Otherwise rdata[k] is the stored value.
  - All NR ports are independent; any ports may read the same address.
- Scoreboard:
  - One busy bit per register.
  - Set: on a rising edge, busy[iss_addr] ← 1 if iss_valid = 1 and iss_addr ≠ 0.
  - Clear: on a rising edge, busy[a] ← 0 for every nonzero address written by an enabled lane.
  - Same edge set and clear on the same address: set wins, and the bit stays 1 (a new producer issued as the old one retired).
  - Two lanes clearing the same address is a single clear.
  - Setting an already-busy register leaves it 1. No counting: the core guarantees at most one outstanding writer per register.
- rbusy[k]:
  - BYPASS = 1: busy[raddr[k]] AND NOT (any enabled lane writes raddr[k] this cycle). Data arriving now is treated as ready.
  - BYPASS = 0: busy[raddr[k]] directly.
  - The same-cycle iss_valid does not affect rbusy; the set is visible from the next cycle.
- any_busy: combinational OR of the stored busy bits.
- No X propagation from uninitialised storage: every entry is defined from reset.

Test Plan:
- Reset/write/read: assert rst_n = 0 mid-run after writing x5 = 0xDEADBEEF → rdata = 0 immediately, asynchronously. Then release, write x5 = 0x12345678 on lane 0 → x5 reads 0x12345678 the next cycle.
- Register 0: write x0 = 0xFFFFFFFF on both lanes and issue iss_addr = 0 → x0 reads 0 and rbusy = 0 on all ports.
- Write collision: lane 0 writes x7 = 0x11, lane 1 writes x7 = 0x22 in the same cycle → x7 = 0x22. With BYPASS = 1, a same-cycle read of x7 returns 0x22.
- Bypass off vs. on: with BYPASS = 0, a read of x3 during a write of 0xAA shows the old value 0x00, then 0xAA the next cycle. With BYPASS = 1, it shows 0xAA in the same cycle.
- Scoreboard:
  - iss x9 → rbusy = 1 and any_busy = 1 the next cycle.
  - Write x9 on lane 1 → rbusy = 0 in the same cycle (BYPASS = 1), stored busy = 0 after the edge, any_busy = 0.
  - Issue x9 and write x9 on the same edge → busy stays 1.
- Port independence (NR = 4): all four ports read x1, x2, x1, x31 after writes 0x1, 0x2, 0x1F → data 0x1, 0x2, 0x1, 0x1F, each with the correct rbusy.
